h80_uart_tx_fifo: RTL and testbench



---
 rtl/h80_uart_pkg.sv | 20 ++
 rtl/h80_byte_fifo.sv | 63 ++++++
 rtl/h80_uart_tx_fifo.sv | 129 ++++++++++++
 tb/tb_h80_uart_tx_fifo.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h80_uart_pkg.sv
// Shared types and helpers for the h80 buffered UART transmitter.
// The parity state is only used when H80_UART_TX_PARITY_EN is defined.
package h80_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    // Round-to-nearest clock divisor for one bit period
    function automatic int uart_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/h80_byte_fifo.sv
// Byte FIFO feeding the UART serializer. DEPTH must be a power of two so
// the pointers wrap naturally. Full is judged before any same-cycle pop,
// so a push into a full FIFO is rejected even if a pop happens alongside.
module h80_byte_fifo
    import h80_uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [UART_DATA_BITS-1:0]   push_data,
    input  logic                        pop,
    output logic [UART_DATA_BITS-1:0]   pop_data,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic                      push_ok;
    logic                      pop_ok;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care after reset so it has none
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/h80_uart_tx_fifo.sv
// Buffered UART transmitter: bytes are queued through a strobe/full
// handshake and sent LSB-first as 8N1 frames, or 8E1 when the macro
// H80_UART_TX_PARITY_EN is defined. Frames run back-to-back while the
// FIFO has data; the next byte is popped on the last stop-bit cycle.
module h80_uart_tx_fifo
    import h80_uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 230400,
    parameter int DEPTH    = 16
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic [7:0]                wr_data,
    input  logic                      wr_en,
    output logic                      full,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      uart_txp
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(UART_DATA_BITS - 1);

    uart_tx_state_e            state;
    logic [CW-1:0]             baud_cnt;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] fifo_data;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic                      bit_end;
`ifdef H80_UART_TX_PARITY_EN
    logic                      parity_bit;
`endif

    h80_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (sysclk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .level     (level),
        .full      (full),
        .empty     (fifo_empty)
    );

    assign bit_end  = (baud_cnt == CNT_LAST);
    assign fifo_pop = !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && bit_end));
    assign busy     = !fifo_empty || (state != IDLE);

    // Sticky overflow flag: a write arrived while the FIFO was full
    always_ff @(posedge sysclk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

    // Serializer FSM with baud counter, shift register and registered line
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_txp <= 1'b1;
`ifdef H80_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (fifo_pop) begin
            shift    <= fifo_data;
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= START;
            uart_txp <= 1'b0;
`ifdef H80_UART_TX_PARITY_EN
            parity_bit <= ^fifo_data;
`endif
        end else if (state != IDLE) begin
            if (!bit_end) begin
                baud_cnt <= baud_cnt + CW'(1);
            end else begin
                baud_cnt <= '0;
                case (state)
                    START: begin
                        state    <= DATA;
                        uart_txp <= shift[0];
                    end
                    DATA: begin
                        if (bit_idx == LAST_BIT) begin
`ifdef H80_UART_TX_PARITY_EN
                            state    <= PARITY;
                            uart_txp <= parity_bit;
`else
                            state    <= STOP;
                            uart_txp <= 1'b1;
`endif
                        end else begin
                            bit_idx  <= bit_idx + IW'(1);
                            shift    <= shift >> 1;
                            uart_txp <= shift[1];
                        end
                    end
`ifdef H80_UART_TX_PARITY_EN
                    PARITY: begin
                        state    <= STOP;
                        uart_txp <= 1'b1;
                    end
`endif
                    default: begin
                        state    <= IDLE;
                        uart_txp <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_h80_uart_tx_fifo.sv
// Self-checking bench for h80_uart_tx_fifo with CLK_FREQ=1000, BAUD=100
// (ten clocks per bit). A line monitor decodes every frame and the
// decoded bytes are compared against the queue of bytes the FIFO should
// have accepted. Honours H80_UART_TX_PARITY_EN for the frame length.
module tb_h80_uart_tx_fifo;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DEPTH    = 16;
    localparam int DIV      = 10;
    localparam int LW       = $clog2(DEPTH) + 1;
`ifdef H80_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit HAS_PARITY = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit HAS_PARITY = 1'b0;
`endif
    localparam int FRAME = FRAME_BITS * DIV;

    logic          sysclk = 1'b0;
    logic          reset  = 1'b1;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_en  = 1'b0;
    logic          full;
    logic          busy;
    logic [LW-1:0] level;
    logic          overflow;
    logic          uart_txp;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int peak  = 0;
    bit track = 1'b0;
    bit mon_en = 1'b0;
    bit mon_busy = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         start_q[$];

    h80_uart_tx_fifo #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .busy     (busy),
        .level    (level),
        .overflow (overflow),
        .uart_txp (uart_txp)
    );

    // Free-running clock and cycle counter
    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Peak FIFO occupancy tracker for the back-to-back scenario
    always @(negedge sysclk) begin
        if (track && int'(level) > peak) peak = int'(level);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected line level for bit slot k of a frame carrying byte b
    function automatic logic frameBit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && HAS_PARITY) return ^b;
        return 1'b1;
    endfunction

    // Re-align the stimulus thread to just after a rising edge
    task automatic align();
        @(posedge sysclk);
        #1;
    endtask

    // One-cycle write strobe; must be entered just after a rising edge
    task automatic applyStimulus(input logic [7:0] b, output int wcyc);
        wr_data = b;
        wr_en   = 1'b1;
        wcyc    = cyc;
        @(posedge sysclk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic waitCycle(input int c);
        @(negedge sysclk);
        while (cyc < c) @(negedge sysclk);
    endtask

    task automatic waitIdle(input int limit);
        int t;
        t = 0;
        while ((busy !== 1'b0 || mon_busy) && t < limit) begin
            @(negedge sysclk);
            t++;
        end
        checkOutput("idle_timeout", (t < limit), 1);
    endtask

    // Line monitor: decodes frames by sampling the middle of each bit
    initial begin
        forever begin
            @(negedge sysclk);
            if (mon_en && uart_txp === 1'b0) begin
                logic [7:0] d;
                mon_busy = 1'b1;
                start_q.push_back(cyc);
                repeat (DIV / 2) @(negedge sysclk);
                checkOutput("mon_start", uart_txp, 0);
                for (int k = 0; k < 8; k++) begin
                    repeat (DIV) @(negedge sysclk);
                    d[k] = uart_txp;
                end
                if (HAS_PARITY) begin
                    repeat (DIV) @(negedge sysclk);
                    checkOutput("mon_parity", uart_txp, ^d);
                end
                repeat (DIV) @(negedge sysclk);
                checkOutput("mon_stop", uart_txp, 1);
                got_q.push_back(d);
                mon_busy = 1'b0;
            end
        end
    end

    // Global safety net so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0, w1, wt, n, gap, occ, acc, fails, idx, pop_cyc, s;
        logic [7:0] b;

        // Reset and idle line
        repeat (5) @(posedge sysclk);
        #1;
        reset = 1'b0;
        @(negedge sysclk);
        checkOutput("rst_txp", uart_txp, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_overflow", overflow, 0);
        fails = 0;
        repeat (200) begin
            @(negedge sysclk);
            if (uart_txp !== 1'b1 || busy !== 1'b0 || level !== '0 || full !== 1'b0) fails++;
        end
        checkOutput("idle_200", fails, 0);

        // Single byte 0x55: latency, bit pattern, busy release
        mon_en = 1'b1;
        align();
        applyStimulus(8'h55, w0);
        exp_q.push_back(8'h55);
        waitCycle(w0 + 1);
        checkOutput("single_level", level, 1);
        checkOutput("single_pre_start", uart_txp, 1);
        waitCycle(w0 + 2);
        checkOutput("single_start_fall", uart_txp, 0);
        for (int k = 1; k < FRAME_BITS; k++) begin
            waitCycle(w0 + 2 + k * DIV + DIV / 2);
            checkOutput($sformatf("single_bit%0d", k), uart_txp, frameBit(8'h55, k));
        end
        waitCycle(w0 + 2 + FRAME - 1);
        checkOutput("single_busy_last", busy, 1);
        waitCycle(w0 + 2 + FRAME);
        checkOutput("single_busy_drop", busy, 0);
        waitIdle(FRAME);

        // Two bytes on consecutive cycles run back-to-back
        idx = start_q.size();
        peak = 0;
        track = 1'b1;
        align();
        applyStimulus(8'hA3, w0);
        applyStimulus(8'h0F, w1);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        waitIdle(3 * FRAME);
        track = 1'b0;
        checkOutput("b2b_peak_level", peak, 1);
        checkOutput("b2b_frames", start_q.size() - idx, 2);
        if (start_q.size() >= idx + 2) begin
            checkOutput("b2b_first_start", start_q[idx], w0 + 2);
            checkOutput("b2b_gap", start_q[idx+1] - start_q[idx], FRAME);
        end

        // Random bursts of at most DEPTH bytes with random spacing
        repeat (4) begin
            n = $urandom_range(1, DEPTH);
            align();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                applyStimulus(b, wt);
                exp_q.push_back(b);
                gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 120);
                repeat (gap) align();
            end
            waitIdle(DEPTH * FRAME + 200);
        end
        checkOutput("rand_overflow", overflow, 0);

        // Fill to DEPTH behind one in-flight frame, then write on the pop cycle
        occ = 0;
        align();
        for (int k = 0; k <= DEPTH; k++) begin
            b = 8'($urandom);
            applyStimulus(b, wt);
            if (k == 0) w0 = wt;
            acc = (occ < DEPTH) ? 1 : 0;
            if (acc == 1) exp_q.push_back(b);
            occ = occ + acc - ((k == 1) ? 1 : 0);
        end
        @(negedge sysclk);
        checkOutput("fill_level", level, occ);
        checkOutput("fill_full", full, (occ == DEPTH) ? 1 : 0);
        checkOutput("fill_overflow", overflow, 0);
        pop_cyc = w0 + 2 + FRAME - 1;
        align();
        while (cyc < pop_cyc) align();
        checkOutput("pop_cycle_full", full, 1);
        applyStimulus(8'hEE, wt);
        occ = occ - 1;
        @(negedge sysclk);
        checkOutput("pop_cycle_wcyc", wt, pop_cyc);
        checkOutput("pop_cycle_level", level, occ);
        checkOutput("pop_cycle_overflow", overflow, 1);
        checkOutput("pop_cycle_full_after", full, 0);
        waitIdle((DEPTH + 2) * FRAME);
        checkOutput("overflow_sticky", overflow, 1);

        // Reset in the middle of a frame with three bytes queued
        mon_en = 1'b0;
        align();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(8'(8'h30 + k), wt);
            if (k == 0) w0 = wt;
        end
        s = w0 + 2;
        while (cyc < s + 45) align();
        checkOutput("abort_queued", level, 3);
        reset = 1'b1;
        align();
        reset = 1'b0;
        @(negedge sysclk);
        checkOutput("abort_txp", uart_txp, 1);
        checkOutput("abort_level", level, 0);
        checkOutput("abort_overflow", overflow, 0);
        checkOutput("abort_busy", busy, 0);
        fails = 0;
        repeat (300) begin
            @(negedge sysclk);
            if (uart_txp !== 1'b1 || busy !== 1'b0 || level !== '0) fails++;
        end
        checkOutput("abort_quiet", fails, 0);

        // Every accepted byte must have left the line, in order
        checkOutput("frame_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checkOutput($sformatf("frame%0d", i), got_q[i], exp_q[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
